// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed program image off a 16-bit
// valid/ready stream, writes it into the ROM write port and releases cpu_resetN once it
// is complete. The checksum word is present only when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
  parameter int INSTR_WIDTH        = 16,
  parameter int ROM_REGISTER_COUNT = 1024,
  parameter int BASE_ADDR          = 0,
  localparam int AW                = $clog2(ROM_REGISTER_COUNT)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [INSTR_WIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic [AW-1:0]          wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   wr_en,
  output logic                   cpu_resetN,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [AW:0]            words_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

  state_t      state;
  logic [AW:0] len;
  logic        beat, restart, len_ok, last_beat;
  logic [31:0] n_word;

  assign beat      = s_valid && s_ready;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign n_word    = 32'(s_data);
  // Upper bound keeps the final write address inside the ROM, so the address never wraps.
  assign len_ok    = (n_word != 32'd0) && (n_word <= 32'(ROM_REGISTER_COUNT - BASE_ADDR));
  assign last_beat = (words_loaded + 1'b1) == len;

`ifdef IMEM_LOADER_CSUM_EN
  logic [INSTR_WIDTH-1:0] acc, csum_sum;
  assign csum_sum = acc + s_data;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      s_ready      <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_resetN   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      acc          <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      // Released one cycle after DONE is entered; dropped in the cycle DONE is left.
      cpu_resetN <= (state == S_DONE) && !start;
      if (restart) begin
        state        <= S_LEN;
        s_ready      <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        acc          <= '0;
`endif
      end else begin
        case (state)
          S_LEN: if (beat) begin
            if (len_ok) begin
              len   <= (AW+1)'(s_data);
              state <= S_DATA;
            end else begin
              state   <= S_ERROR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              error   <= 1'b1;
            end
          end
          S_DATA: if (beat) begin
            wr_en        <= 1'b1;
            wr_data      <= s_data;
            wr_addr      <= AW'(BASE_ADDR) + words_loaded[AW-1:0];
            words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            acc          <= acc + s_data;
            if (last_beat) state <= S_CSUM;
`else
            if (last_beat) begin
              state   <= S_DONE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
`endif
          end
`ifdef IMEM_LOADER_CSUM_EN
          S_CSUM: if (beat) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (csum_sum == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
